// File: rtl/granule_parameter_bank_pkg.sv
// -----------------------------------------------------------------------------
// granule_parameter_bank_pkg
//   Shared constants for the granule parameter bank: where each decoded field
//   lives in the bank (channel / field index) and helpers that turn an index
//   pair into a flat slot number or size an index bus.
// -----------------------------------------------------------------------------
package granule_parameter_bank_pkg;

    // Granule header fields are stored in channel 0.
    localparam int HDR_CH = 0;

    // Per-channel side-information field indices.
    localparam int FLD_BIG_VALUES        = 0;
    localparam int FLD_GLOBAL_GAIN       = 1;
    localparam int FLD_SCALEFAC_COMPRESS = 2;
    localparam int FLD_WIN_SWITCH        = 3;
    localparam int FLD_BLOCK_TYPE        = 4;
    localparam int FLD_MIXED_BLOCK       = 5;
    localparam int FLD_TABLE_SEL0        = 6;
    localparam int FLD_TABLE_SEL1        = 7;
    localparam int FLD_TABLE_SEL2        = 8;
    localparam int FLD_REGION0_COUNT     = 9;
    localparam int FLD_REGION1_COUNT     = 10;
    localparam int FLD_COUNT1_TABLE_SEL  = 11;

    // Flat slot number of (channel, field); slot s occupies
    // active_data[s*DATA_W +: DATA_W].
    function automatic int slot_offset(input int ch, input int field,
                                       input int fields_per_ch);
        return ch * fields_per_ch + field;
    endfunction

    // Width of an index bus for n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/granule_parameter_bank_slot_reg.sv
// -----------------------------------------------------------------------------
// param_slot_reg
//   One parameter slot: a staging register written by the parser, an active
//   register read by the decoding chain, and a flag telling whether the slot
//   was written during the granule now in the active register.
//
//   clk, rst  clock, asynchronous active-high reset
//   wr_en     write this slot's staging register with wr_data
//   wr_data   field value
//   commit    copy staging -> active and written-flag -> active written bit
//   active    active field value
//   written   slot was written during the committed granule
// -----------------------------------------------------------------------------
module param_slot_reg #(
    parameter int DATA_W          = 8,
    parameter bit CLEAR_ON_COMMIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    output logic [DATA_W-1:0] active,
    output logic              written
);

    logic [DATA_W-1:0] stage;
    logic              wmask;

    // NOTE: every storage bit here is a plain flop, so all of it is reset;
    // the bank is small enough that no RAM macro is involved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage   <= '0;
            wmask   <= 1'b0;
            active  <= '0;
            written <= 1'b0;
        end else if (commit) begin
            // NOTE: non-blocking assignments let active take the old stage
            // value even when stage is cleared on the same edge.
            active  <= stage;
            written <= wmask;
            wmask   <= 1'b0;
            if (CLEAR_ON_COMMIT) begin
                stage <= '0;
            end
        end else if (wr_en) begin
            // Writes are only granted while not pending, and a commit only
            // happens while pending, so the two never coincide.
            stage <= wr_data;
            wmask <= 1'b1;
        end
    end

endmodule

// File: rtl/granule_parameter_bank.sv
// -----------------------------------------------------------------------------
// granule_parameter_bank
//   Double-buffered parameter bank of NUM_CH x FIELDS_PER_CH fields. The parser
//   fills the staging bank and pulses stage_done; the staging bank is then
//   committed to the active bank as soon as the decoding chain has released
//   it (chain_done), and chain_start announces the new active contents.
//
//   clk, rst        clock, asynchronous active-high reset
//   wr_en           staging write strobe
//   wr_ch/wr_field  channel / field index of the write
//   wr_data         field value (zero-extended by the writer)
//   stage_ready     staging bank accepts writes and stage_done
//   stage_done      one-cycle pulse: staging complete
//   chain_start     one-cycle pulse: active bank updated
//   chain_done      one-cycle pulse: chain finished with the active bank
//   busy            active bank owned by the chain
//   active_data     active bank, slot s at [s*DATA_W +: DATA_W]
//   active_written  per-slot written flags of the committed granule
//   wr_err          sticky: a write was rejected (pending or out of range)
// -----------------------------------------------------------------------------
module granule_parameter_bank
    import granule_parameter_bank_pkg::*;
#(
    parameter  int NUM_CH          = 2,
    parameter  int FIELDS_PER_CH   = 12,
    parameter  int DATA_W          = 8,
    parameter  bit CLEAR_ON_COMMIT = 1'b0,
    localparam int NUM_SLOTS       = NUM_CH * FIELDS_PER_CH,
    localparam int CH_W            = idx_width(NUM_CH),
    localparam int FLD_W           = idx_width(FIELDS_PER_CH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [CH_W-1:0]             wr_ch,
    input  logic [FLD_W-1:0]            wr_field,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        stage_ready,
    input  logic                        stage_done,
    output logic                        chain_start,
    input  logic                        chain_done,
    output logic                        busy,
    output logic [NUM_SLOTS*DATA_W-1:0] active_data,
    output logic [NUM_SLOTS-1:0]        active_written,
    output logic                        wr_err
);

    logic                 pending;
    logic                 in_range;
    logic                 wr_ok;
    logic                 commit;
    int                   wr_slot;
    logic [NUM_SLOTS-1:0] slot_wr;

    // Indices are widened before comparing so a bus that can only encode
    // legal values does not turn the range check into a width artefact.
    assign in_range    = (32'(wr_ch) < NUM_CH) && (32'(wr_field) < FIELDS_PER_CH);
    assign wr_ok       = wr_en && !pending && in_range;
    assign wr_slot     = slot_offset(32'(wr_ch), 32'(wr_field), FIELDS_PER_CH);
    assign commit      = pending && !busy;
    assign stage_ready = !pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= 1'b0;
            busy        <= 1'b0;
            chain_start <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            chain_start <= commit;
            if (wr_en && !wr_ok) begin
                wr_err <= 1'b1;
            end
            if (commit) begin
                pending <= 1'b0;
                busy    <= 1'b1;
            end else begin
                // stage_done while pending and chain_done while idle are
                // ignored. A chain_done on the same edge as a pending granule
                // frees the bank; the commit follows on the next edge.
                if (stage_done && !pending) begin
                    pending <= 1'b1;
                end
                if (chain_done && busy) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        assign slot_wr[s] = wr_ok && (wr_slot == s);

        param_slot_reg #(
            .DATA_W          (DATA_W),
            .CLEAR_ON_COMMIT (CLEAR_ON_COMMIT)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (slot_wr[s]),
            .wr_data (wr_data),
            .commit  (commit),
            .active  (active_data[s*DATA_W +: DATA_W]),
            .written (active_written[s])
        );
    end

endmodule

// File: tb/tb_granule_parameter_bank.sv
// -----------------------------------------------------------------------------
// tb_granule_parameter_bank
//   Two banks share one stimulus stream: A (2 channels, sticky staging) and
//   B (3 channels, staging cleared on commit). A behavioural model tracks the
//   banks as arrays; each commit it predicts pushes the expected active bank
//   into a queue that a separate monitor pops when chain_start is seen.
// -----------------------------------------------------------------------------
module tb_granule_parameter_bank;

    localparam int FPC = 12;
    localparam int DW  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, stage_done, chain_done;
    logic [1:0]  wr_ch;
    logic [3:0]  wr_field;
    logic [7:0]  wr_data;

    logic         stage_ready_a, chain_start_a, busy_a, wr_err_a;
    logic [191:0] active_data_a;
    logic [23:0]  active_written_a;
    logic         stage_ready_b, chain_start_b, busy_b, wr_err_b;
    logic [287:0] active_data_b;
    logic [35:0]  active_written_b;

    always #5 clk = ~clk;

    granule_parameter_bank #(
        .NUM_CH(2), .FIELDS_PER_CH(FPC), .DATA_W(DW), .CLEAR_ON_COMMIT(1'b0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch[0]), .wr_field(wr_field),
        .wr_data(wr_data), .stage_ready(stage_ready_a), .stage_done(stage_done),
        .chain_start(chain_start_a), .chain_done(chain_done), .busy(busy_a),
        .active_data(active_data_a), .active_written(active_written_a), .wr_err(wr_err_a)
    );

    granule_parameter_bank #(
        .NUM_CH(3), .FIELDS_PER_CH(FPC), .DATA_W(DW), .CLEAR_ON_COMMIT(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_field(wr_field),
        .wr_data(wr_data), .stage_ready(stage_ready_b), .stage_done(stage_done),
        .chain_start(chain_start_b), .chain_done(chain_done), .busy(busy_b),
        .active_data(active_data_b), .active_written(active_written_b), .wr_err(wr_err_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           cyc;
        logic [287:0] da;
        logic [35:0]  wa;
        logic [287:0] db;
        logic [35:0]  wb;
    } exp_t;

    exp_t         q[$];
    int           cyc;
    bit           m_pending, m_busy, m_cs;
    bit           m_err[2];
    logic [287:0] m_stage[2];
    logic [287:0] m_active[2];
    logic [35:0]  m_wmask[2];
    logic [35:0]  m_written[2];

    function automatic int nch(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    task automatic model_edge();
        bit   commit;
        int   ch, slot;
        exp_t e;
        cyc++;
        commit = m_pending && !m_busy;
        m_cs   = commit;
        for (int d = 0; d < 2; d++) begin
            ch = (d == 0) ? int'(wr_ch[0]) : int'(wr_ch);
            if (commit) begin
                m_active[d]  = m_stage[d];
                m_written[d] = m_wmask[d];
                m_wmask[d]   = '0;
                if (d == 1) m_stage[d] = '0;
            end
            if (wr_en) begin
                if (!m_pending && ch < nch(d) && int'(wr_field) < FPC) begin
                    slot = ch * FPC + int'(wr_field);
                    m_stage[d][slot*DW +: DW] = wr_data;
                    m_wmask[d][slot] = 1'b1;
                end else begin
                    m_err[d] = 1'b1;
                end
            end
        end
        if (commit) begin
            m_pending = 1'b0;
            m_busy    = 1'b1;
            e.cyc = cyc;
            e.da  = m_active[0];
            e.wa  = m_written[0];
            e.db  = m_active[1];
            e.wb  = m_written[1];
            q.push_back(e);
        end else begin
            if (stage_done && !m_pending) m_pending = 1'b1;
            if (chain_done && m_busy)     m_busy    = 1'b0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; m_pending = 0; m_busy = 0; m_cs = 0;
            for (int d = 0; d < 2; d++) begin
                m_err[d] = 0; m_stage[d] = '0; m_active[d] = '0;
                m_wmask[d] = '0; m_written[d] = '0;
            end
            q.delete();
        end else begin
            model_edge();
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            check("stage_ready_a", stage_ready_a, !m_pending);
            check("stage_ready_b", stage_ready_b, !m_pending);
            check("busy_a", busy_a, m_busy);
            check("busy_b", busy_b, m_busy);
            check("chain_start_a", chain_start_a, m_cs);
            check("chain_start_b", chain_start_b, m_cs);
            check("wr_err_a", wr_err_a, m_err[0]);
            check("wr_err_b", wr_err_b, m_err[1]);
            check("active_data_a", active_data_a, m_active[0][191:0]);
            check("active_data_b", active_data_b, m_active[1]);
            if (chain_start_a) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_commit: chain_start seen, no granule expected (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    check("commit_cycle", cyc, e.cyc);
                    check("commit_data_a", active_data_a, e.da[191:0]);
                    check("commit_written_a", active_written_a, e.wa[23:0]);
                    check("commit_data_b", active_data_b, e.db);
                    check("commit_written_b", active_written_b, e.wb);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        wr_en = 0; stage_done = 0; chain_done = 0;
        wr_ch = 0; wr_field = 0; wr_data = 0;
    endtask

    task automatic wr(input int ch, input int f, input logic [7:0] d);
        wr_en = 1; wr_ch = 2'(ch); wr_field = 4'(f); wr_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        do_reset();

        // Reset state
        check("rst_ready", stage_ready_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_data", active_data_a, 0);
        check("rst_written", active_written_a, 0);

        // Single write, commit while idle: two-edge latency
        wr(1, 3, 8'hA5); step();
        idle(); stage_done = 1; step();
        stage_done = 0;
        check("t1_ready_low", stage_ready_a, 0);
        step();
        check("t1_ready_back", stage_ready_a, 1);
        check("t1_chain_start", chain_start_a, 1);
        check("t1_slot15", active_data_a[15*8 +: 8], 8'hA5);
        check("t1_written", active_written_a, 24'h008000);
        step();
        check("t1_pulse_end", chain_start_a, 0);

        // Granule 2 while busy, with write+stage_done in one cycle
        wr(0, 0, 8'h11); step();
        wr(1, 11, 8'h22); stage_done = 1; step();
        idle(); wr(0, 5, 8'h33); step();
        idle();
        check("t2_err_pending", wr_err_a, 1);
        step(); step();
        check("t2_held_busy", chain_start_a, 0);
        chain_done = 1; step();
        idle();
        check("t2_busy_clear", busy_a, 0);
        check("t2_no_zero_gap", chain_start_a, 0);
        step();
        check("t2_chain_start", chain_start_a, 1);
        check("t2_slot0", active_data_a[0 +: 8], 8'h11);
        check("t2_slot23", active_data_a[23*8 +: 8], 8'h22);
        check("t2_slot5", active_data_a[5*8 +: 8], 8'h00);
        check("t2_written", active_written_a, 24'h800001);
        chain_done = 1; step(); idle();

        // Commit with no writes: sticky (A) versus cleared (B)
        stage_done = 1; step(); idle(); step();
        check("t4_chain_start", chain_start_a, 1);
        check("t4_sticky_slot15", active_data_a[15*8 +: 8], 8'hA5);
        check("t4_sticky_slot0", active_data_a[0 +: 8], 8'h11);
        check("t4_written_a", active_written_a, 0);
        check("t4_cleared_b", active_data_b, 0);
        chain_done = 1; step(); idle();

        // Out-of-range channel (B only) and field (both)
        do_reset();
        wr(3, 2, 8'h5A); step(); idle();
        check("t3_ch_err_b", wr_err_b, 1);
        check("t3_ch_ok_a", wr_err_a, 0);
        do_reset();
        wr(0, 12, 8'h77); step(); idle();
        check("t3_fld_err_a", wr_err_a, 1);
        check("t3_fld_err_b", wr_err_b, 1);
        stage_done = 1; step(); idle(); step();
        check("t3_commit", chain_start_a, 1);
        check("t3_no_written", active_written_a, 0);
        check("t3_no_data", active_data_a, 0);

        // stage_done and chain_done on the same edge while busy
        stage_done = 1; chain_done = 1; step(); idle();
        check("t5_busy_clear", busy_a, 0);
        check("t5_pending", stage_ready_a, 0);
        check("t5_not_yet", chain_start_a, 0);
        step();
        check("t5_commit", chain_start_a, 1);
        step();
        check("t5_single", chain_start_a, 0);

        // chain_done on the edge that sees a pending granule
        stage_done = 1; step(); idle(); step();
        check("t5b_wait", chain_start_a, 0);
        chain_done = 1; step(); idle();
        check("t5b_not_yet", chain_start_a, 0);
        step();
        check("t5b_commit", chain_start_a, 1);

        // Asynchronous reset while pending and busy
        stage_done = 1; step(); idle();
        wr(0, 1, 8'h09); step(); idle();
        check("t6_pending", stage_ready_a, 0);
        check("t6_busy", busy_a, 1);
        check("t6_err", wr_err_a, 1);
        #2 rst = 1;
        #1;
        check("t6_ready", stage_ready_a, 1);
        check("t6_busy_rst", busy_a, 0);
        check("t6_err_rst", wr_err_a, 0);
        check("t6_data_a", active_data_a, 0);
        check("t6_written_a", active_written_a, 0);
        check("t6_data_b", active_data_b, 0);
        check("t6_ready_b", stage_ready_b, 1);
        step();
        rst = 0;
        idle();

        // Randomised segments
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                wr_en      = ($urandom % 2) == 0;
                wr_ch      = 2'($urandom % 4);
                wr_field   = 4'($urandom % 14);
                wr_data    = 8'($urandom);
                stage_done = ($urandom % (3 + seg)) == 0;
                chain_done = ($urandom % (2 + seg)) == 0;
                step();
            end
        end

        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
